// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram play engine.
// Build option: NONOGRAM_AUTOBLOCK_EN (wrong paints also mark the cell blocked).
package nonogram_pkg;

   localparam int N_DEFAULT         = 10;
   localparam int LEVELS_DEFAULT    = 3;
   localparam int MAX_WRONG_DEFAULT = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PLAY  = 3'd2,
      ST_CLEAR = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // Key actions in decreasing priority; only one is taken per cycle.
   typedef enum logic [2:0] {
      ACT_NONE  = 3'd0,
      ACT_START = 3'd1,
      ACT_UP    = 3'd2,
      ACT_DOWN  = 3'd3,
      ACT_LEFT  = 3'd4,
      ACT_RIGHT = 3'd5,
      ACT_PAINT = 3'd6,
      ACT_BLOCK = 3'd7
   } action_t;

   function automatic int cell_index(input int y, input int x, input int n);
      return y * n + x;
   endfunction

endpackage

// File: rtl/nonogram_level_rom.sv
// Combinational puzzle ROM: returns one N-bit solution row of the chosen level.
// Stored rows are 10 cells wide; other board sizes zero-pad or truncate them.
module nonogram_level_rom
   import nonogram_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int LW = 2,
   parameter int CW = $clog2(N)
)(
   input  logic [LW-1:0] level,
   input  logic [CW-1:0] row,
   output logic [N-1:0]  row_bits
);

   localparam int SW = 10;

   // Bit x of each row word is the solution for column x.
   localparam logic [SW-1:0] ROM_BITS [3][SW] = '{
      '{10'h030, 10'h078, 10'h0FC, 10'h1FE, 10'h3FF, 10'h3FF, 10'h1FE, 10'h0FC, 10'h078, 10'h030},
      '{10'h201, 10'h102, 10'h084, 10'h048, 10'h030, 10'h030, 10'h048, 10'h084, 10'h102, 10'h201},
      '{10'h3FF, 10'h201, 10'h201, 10'h201, 10'h201, 10'h201, 10'h201, 10'h201, 10'h201, 10'h3FF}
   };

   logic [SW-1:0] word_s;

   // Row lookup; levels beyond the stored three get a diagonal pattern.
   always_comb begin
      word_s = 10'h000;
      for (int r = 0; r < SW; r++) begin
         for (int l = 0; l < 3; l++) begin
            word_s = (int'(row) == r && int'(level) == l) ? ROM_BITS[l][r] : word_s;
         end
      end
      word_s = (int'(level) >= 3 && int'(row) < SW) ? (10'h001 << row) : word_s;
   end

   generate
      if (N > SW) begin : g_pad
         assign row_bits = {{(N-SW){1'b0}}, word_s};
      end else begin : g_trunc
         assign row_bits = word_s[N-1:0];
      end
   endgenerate

endmodule

// File: rtl/nonogram_engine.sv
// Nonogram play engine: level load sequencer, cursor, paint/block board and win/lose detection.
// Build option: NONOGRAM_AUTOBLOCK_EN (a wrong paint also sets the cell's block bit).
module nonogram_engine
   import nonogram_pkg::*;
#(
   parameter  int N         = N_DEFAULT,
   parameter  int LEVELS    = LEVELS_DEFAULT,
   parameter  int MAX_WRONG = MAX_WRONG_DEFAULT,
   localparam int CW        = $clog2(N),
   localparam int LW        = (LEVELS > 1) ? $clog2(LEVELS) : 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LW-1:0]   level_sel,
   input  logic            key_up,
   input  logic            key_down,
   input  logic            key_left,
   input  logic            key_right,
   input  logic            key_paint,
   input  logic            key_block,
   output logic [CW-1:0]   cur_x,
   output logic [CW-1:0]   cur_y,
   output logic [N*N-1:0]  paint,
   output logic [N*N-1:0]  block,
   output logic [LW-1:0]   cur_level,
   output logic [LW-1:0]   next_level,
   output logic [3:0]      wrong_count,
   output logic            busy,
   output logic            level_clear,
   output logic            game_over
);

   localparam int NN = N * N;
   localparam int IW = $clog2(NN);

   state_t          state_r, state_s;
   action_t         act_s;
   logic [CW-1:0]   row_r, row_s, x_s, y_s;
   logic [NN-1:0]   sol_r, sol_s, paint_s, block_s;
   logic [LW-1:0]   level_s, load_level_s, sel_s;
   logic [3:0]      wrong_s;
   logic            load_s;
   logic [IW-1:0]   idx_s;
   logic [N-1:0]    rom_row_s;

   nonogram_level_rom #(.N(N), .LW(LW), .CW(CW)) u_rom (
      .level    (cur_level),
      .row      (row_r),
      .row_bits (rom_row_s)
   );

   assign idx_s = IW'(cell_index(int'(cur_y), int'(cur_x), N));
   assign sel_s = (int'(level_sel) >= LEVELS) ? LW'(0) : level_sel;

   // Key priority encoder.
   always_comb begin
      if (start)          act_s = ACT_START;
      else if (key_up)    act_s = ACT_UP;
      else if (key_down)  act_s = ACT_DOWN;
      else if (key_left)  act_s = ACT_LEFT;
      else if (key_right) act_s = ACT_RIGHT;
      else if (key_paint) act_s = ACT_PAINT;
      else if (key_block) act_s = ACT_BLOCK;
      else                act_s = ACT_NONE;
   end

   // Next-state and board update logic.
   always_comb begin
      state_s      = state_r;
      row_s        = row_r;
      x_s          = cur_x;
      y_s          = cur_y;
      sol_s        = sol_r;
      paint_s      = paint;
      block_s      = block;
      wrong_s      = wrong_count;
      level_s      = cur_level;
      load_s       = 1'b0;
      load_level_s = cur_level;
      case (state_r)
         ST_IDLE: begin
            load_s       = (act_s == ACT_START);
            load_level_s = sel_s;
         end
         ST_LOAD: begin
            for (int r = 0; r < N; r++) begin
               sol_s[r*N +: N] = (int'(row_r) == r) ? rom_row_s : sol_r[r*N +: N];
            end
            if (row_r == CW'(N-1)) begin
               state_s = ST_PLAY;
               row_s   = CW'(0);
            end else begin
               row_s   = row_r + CW'(1);
            end
         end
         ST_PLAY: begin
            case (act_s)
               ACT_START: load_s = 1'b1;
               ACT_UP:    y_s = (cur_y == CW'(0))   ? CW'(N-1) : cur_y - CW'(1);
               ACT_DOWN:  y_s = (cur_y == CW'(N-1)) ? CW'(0)   : cur_y + CW'(1);
               ACT_LEFT:  x_s = (cur_x == CW'(0))   ? CW'(N-1) : cur_x - CW'(1);
               ACT_RIGHT: x_s = (cur_x == CW'(N-1)) ? CW'(0)   : cur_x + CW'(1);
               ACT_PAINT: begin
                  if (paint[idx_s] | block[idx_s]) begin
                     paint_s = paint;
                  end else if (sol_r[idx_s]) begin
                     paint_s[idx_s] = 1'b1;
                  end else begin
                     wrong_s = (wrong_count < 4'(MAX_WRONG)) ? wrong_count + 4'd1 : wrong_count;
`ifdef NONOGRAM_AUTOBLOCK_EN
                     block_s[idx_s] = 1'b1;
`else
                     block_s = block;
`endif
                  end
               end
               ACT_BLOCK: begin
                  if (!paint[idx_s]) block_s[idx_s] = ~block[idx_s];
                  else               block_s = block;
               end
               default: load_s = 1'b0;
            endcase
            // Completion looks at the registered board, so it lags the last paint by one cycle.
            if (wrong_s == 4'(MAX_WRONG)) state_s = ST_OVER;
            else if (paint == sol_r)      state_s = ST_CLEAR;
            else                          state_s = ST_PLAY;
         end
         ST_CLEAR: begin
            load_s       = (act_s == ACT_START);
            load_level_s = next_level;
         end
         ST_OVER: begin
            load_s       = (act_s == ACT_START);
            load_level_s = cur_level;
         end
         default: state_s = ST_IDLE;
      endcase
      if (load_s) begin
         state_s = ST_LOAD;
         level_s = load_level_s;
         row_s   = CW'(0);
         x_s     = CW'(0);
         y_s     = CW'(0);
         paint_s = '0;
         block_s = '0;
         wrong_s = 4'd0;
      end else begin
         level_s = cur_level;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         row_r       <= CW'(0);
         sol_r       <= '0;
         cur_x       <= CW'(0);
         cur_y       <= CW'(0);
         paint       <= '0;
         block       <= '0;
         cur_level   <= LW'(0);
         next_level  <= LW'(1 % LEVELS);
         wrong_count <= 4'd0;
         busy        <= 1'b0;
         level_clear <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state_r     <= state_s;
         row_r       <= row_s;
         sol_r       <= sol_s;
         cur_x       <= x_s;
         cur_y       <= y_s;
         paint       <= paint_s;
         block       <= block_s;
         cur_level   <= level_s;
         next_level  <= (level_s == LW'(LEVELS-1)) ? LW'(0) : level_s + LW'(1);
         wrong_count <= wrong_s;
         busy        <= (state_s == ST_LOAD);
         level_clear <= (state_s == ST_CLEAR);
         game_over   <= (state_s == ST_OVER);
      end
   end

endmodule

// File: doc/nonogram_engine.md
# nonogram_engine

Parametrised nonogram play engine: holds an N×N paint/block board, moves a cursor from key pulses, and checks each paint against the solution bitmap of the selected level. Counts wrong paints toward a game-over limit, detects level completion and sequences to the next level. Sits between the key/control front end and the display renderer; solutions come from an internal level ROM.

## Interface
- N, default 10: board side length, 4..16.
- LEVELS, default 3: number of stored puzzles, 1..8.
- MAX_WRONG, default 3: wrong paints that end the game, 1..15.
- Derived: CW = $clog2(N) (cursor width), LW = max(1,$clog2(LEVELS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that loads a level.
- level_sel  in  LW  level loaded by start from IDLE.
- key_up / key_down / key_left / key_right  in  1 each  one-cycle move pulses.
- key_paint / key_block  in  1 each  one-cycle action pulses.
- cur_x / cur_y  out  CW  cursor column/row.
- paint  out  N*N  painted cells, bit index y*N+x.
- block  out  N*N  blocked (X-marked) cells, same indexing.
- cur_level  out  LW  level in play.
- next_level  out  LW  (cur_level+1) mod LEVELS.
- wrong_count  out  4  wrong paints this level.
- busy  out  1  high in LOAD.
- level_clear  out  1  high in CLEAR.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, LOAD, PLAY, CLEAR, OVER.
- IDLE: start → LOAD with level level_sel (values ≥ LEVELS map to 0).
- LOAD: clears paint, block, wrong_count, cursor to (0,0); copies solution one row per cycle (row 0..N-1) into the solution register; after row N-1 → PLAY.
- PLAY: one action per cycle, priority start > up > down > left > right > paint > block; lower-priority pulses in the same cycle are dropped.
  - Moves wrap: up from y=0 → N-1, down from N-1 → 0; left/right likewise on x.
  - paint on cell already painted or blocked: ignored.
  - paint on cell with solution 1: set paint bit.
  - paint on cell with solution 0: wrong_count+1, paint bit unchanged.
  - block: toggles block bit if cell not painted; ignored if painted.
  - start in PLAY: restart current level (→ LOAD).
- Completion: when paint equals solution → CLEAR. Blocks never affect completion.
- wrong_count reaching MAX_WRONG → OVER; has priority over completion on the same edge.
- CLEAR: keys ignored; start loads next_level.
- OVER: keys ignored; start reloads cur_level.
- wrong_count saturates at MAX_WRONG.

## Timing
- rst low at an edge: state IDLE, all outputs 0, next_level = 1 mod LEVELS, solution register 0.
- start at edge t → busy at t+1; rows loaded edges t+1..t+N; PLAY (busy low) at t+N+1. Keys during LOAD dropped.
- Move/paint/block at edge t → cur_*, paint, block, wrong_count updated at t+1.
- game_over asserts at t+1 (same edge wrong_count reaches MAX_WRONG).
- level_clear asserts at t+2: comparison runs on registered paint.
- Keys in the cycle between a completing paint and CLEAR entry are processed normally; a wrong paint there still counts and may force OVER.
- rst mid-LOAD or mid-PLAY: abandons immediately to IDLE.

## Configuration
- NONOGRAM_AUTOBLOCK_EN defined: a wrong paint also sets that cell's block bit at the same edge as wrong_count increments, so a repeated wrong paint on it is ignored.
- Undefined: a wrong paint only increments wrong_count; repeating it on the same cell counts again.

## Structure
- Package nonogram_pkg: state enum, key-priority constants, N/LEVELS defaults, function for the y*N+x index.
- Sub-module nonogram_level_rom: combinational, inputs level and row, output N-bit row; holds the puzzle bitmaps (level 0 is a 10×10 row set; other sizes zero-pad/truncate).
- Engine FSM, cursor, board registers and comparator in nonogram_engine.

## Test plan
- Reset, start with level_sel=0, N=10 → busy high 10 cycles, PLAY at t+11, cursor (0,0), paint=0, wrong_count=0.
- Cursor at (0,0), key_left then key_up → (9,0) then (9,9); key_up+key_paint same cycle → only the move happens.
- Paint a solution-0 cell three times, MAX_WRONG=3, AUTOBLOCK off → wrong_count 1,2,3, game_over at third +1; AUTOBLOCK on → wrong_count 1, block bit set, later paints ignored.
- Paint every solution-1 cell of level 1 → level_clear 2 cycles after last paint; start → LOAD of level 2, next_level=0.
- In OVER, key presses → no change; start → reload same level, wrong_count 0.
- Drop rst low during LOAD row 5 → IDLE next cycle, all outputs 0.
